// File: rtl/mipsx_pipe_pkg.sv
// Shared pipeline definitions: register index width, default sizes and the
// classification of operand-read hazards.
package mipsx_pipe_pkg;

   localparam int unsigned REG_IDX_W = 5;
   localparam int unsigned NREG      = 32;
   localparam int unsigned DATA_W    = 32;

   typedef enum logic [2:0] {
      HZ_NONE,
      HZ_LOAD_USE,
      HZ_LONG_PENDING,
      HZ_WAW,
      HZ_NO_BYPASS
   } hazard_cause_e;

   // Keep the first reported cause; later causes only fill an empty slot.
   function automatic hazard_cause_e merge_cause(input hazard_cause_e first,
                                                 input hazard_cause_e second);
      merge_cause = (first != HZ_NONE) ? first : second;
   endfunction

endpackage

// File: rtl/regread_scoreboard.sv
// Bitmap of destinations owned by in-flight LateALU ops: one set port, one
// clear port, flush, and three combinational lookups (rs, rt, rd).
module regread_scoreboard
   import mipsx_pipe_pkg::*;
#(
   parameter int unsigned NREG = mipsx_pipe_pkg::NREG
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 set_en,
   input  logic [REG_IDX_W-1:0] set_idx,
   input  logic                 clr_en,
   input  logic [REG_IDX_W-1:0] clr_idx,
   input  logic [REG_IDX_W-1:0] rd_idx_a,
   input  logic [REG_IDX_W-1:0] rd_idx_b,
   input  logic [REG_IDX_W-1:0] rd_idx_c,
   output logic                 busy_a,
   output logic                 busy_b,
   output logic                 busy_c
);

   logic [NREG-1:0] sb_q;
   logic [NREG-1:0] sb_d;

   // Clear is applied before set so a same-cycle set of the same bit wins.
   always_comb begin
      sb_d = sb_q;
      if (clr_en) begin
         sb_d[clr_idx] = 1'b0;
      end
      if (set_en && (set_idx != '0)) begin
         sb_d[set_idx] = 1'b1;
      end
      if (flush) begin
         sb_d = '0;
      end
      sb_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sb_q <= '0;
      end else begin
         sb_q <= sb_d;
      end
   end

   assign busy_a = sb_q[rd_idx_a];
   assign busy_b = sb_q[rd_idx_b];
   assign busy_c = sb_q[rd_idx_c];

endmodule

// File: rtl/pipeline_regread.sv
// Operand-read stage: regfile read with EX/MEM/WB bypass, LateALU scoreboard
// and a single valid/ready output register toward EX. Define
// REGREAD_BYPASS_EN to enable EX/MEM bypass; otherwise those matches stall.
module pipeline_regread
   import mipsx_pipe_pkg::*;
#(
   parameter int unsigned NREG    = mipsx_pipe_pkg::NREG,
   parameter int unsigned DATA_W  = mipsx_pipe_pkg::DATA_W,
   parameter int unsigned STALL_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [REG_IDX_W-1:0] rs_index,
   input  logic [REG_IDX_W-1:0] rt_index,
   input  logic                 rs_used,
   input  logic                 rt_used,
   input  logic [REG_IDX_W-1:0] rd_index,
   input  logic                 long_op,
   output logic [REG_IDX_W-1:0] rindex_a,
   output logic [REG_IDX_W-1:0] rindex_b,
   input  logic [DATA_W-1:0]    rout_a,
   input  logic [DATA_W-1:0]    rout_b,
   input  logic                 ex_valid,
   input  logic [REG_IDX_W-1:0] ex_rd,
   input  logic                 ex_is_load,
   input  logic [DATA_W-1:0]    ex_value,
   input  logic                 mem_valid,
   input  logic [REG_IDX_W-1:0] mem_rd,
   input  logic [DATA_W-1:0]    mem_value,
   input  logic                 we,
   input  logic [REG_IDX_W-1:0] windex,
   input  logic [DATA_W-1:0]    win,
   input  logic                 latealu_done,
   input  logic [REG_IDX_W-1:0] latealu_rd,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_W-1:0]    rs_value,
   output logic [DATA_W-1:0]    rt_value,
   output logic [REG_IDX_W-1:0] out_rd,
   output logic                 out_long_op,
   output logic [STALL_W-1:0]   stall_cycles
);

   logic                 out_valid_q,   out_valid_d;
   logic [DATA_W-1:0]    rs_value_q,    rs_value_d;
   logic [DATA_W-1:0]    rt_value_q,    rt_value_d;
   logic [REG_IDX_W-1:0] out_rd_q,      out_rd_d;
   logic                 out_long_op_q, out_long_op_d;
   logic [STALL_W-1:0]   stall_q,       stall_d;

   logic          sb_busy_a, sb_busy_b, sb_busy_rd;
   logic          accept, hazard;
   hazard_cause_e cause_a, cause_b, cause_waw, hazard_cause;
   logic [DATA_W-1:0] op_a, op_b;

   assign rindex_a = rs_index;
   assign rindex_b = rt_index;

   function automatic hazard_cause_e src_cause(input logic                 used,
                                               input logic [REG_IDX_W-1:0] idx,
                                               input logic                 busy);
      src_cause = HZ_NONE;
      if (used && (idx != '0)) begin
         if (ex_valid && ex_is_load && (ex_rd == idx)) begin
            src_cause = HZ_LOAD_USE;
         end else if (busy) begin
            src_cause = HZ_LONG_PENDING;
         end
`ifndef REGREAD_BYPASS_EN
         else if ((ex_valid && (ex_rd == idx)) || (mem_valid && (mem_rd == idx))) begin
            src_cause = HZ_NO_BYPASS;
         end
`endif
      end
   endfunction

   function automatic logic [DATA_W-1:0] select_operand(input logic [REG_IDX_W-1:0] idx,
                                                        input logic [DATA_W-1:0]    rf);
      select_operand = rf;
      if (idx == '0) begin
         select_operand = '0;
      end
`ifdef REGREAD_BYPASS_EN
      else if (ex_valid && !ex_is_load && (ex_rd == idx)) begin
         select_operand = ex_value;
      end else if (mem_valid && (mem_rd == idx)) begin
         select_operand = mem_value;
      end
`endif
      else if (we && (windex == idx)) begin
         select_operand = win;
      end
   endfunction

`ifndef REGREAD_BYPASS_EN
   logic unused_bypass_data;
   assign unused_bypass_data = ^{ex_value, mem_value};
`endif

   always_comb begin
      cause_a      = src_cause(rs_used, rs_index, sb_busy_a);
      cause_b      = src_cause(rt_used, rt_index, sb_busy_b);
      cause_waw    = (long_op && sb_busy_rd) ? HZ_WAW : HZ_NONE;
      hazard_cause = merge_cause(merge_cause(cause_a, cause_b), cause_waw);
      hazard       = (hazard_cause != HZ_NONE);
      op_a         = select_operand(rs_index, rout_a);
      op_b         = select_operand(rt_index, rout_b);
   end

   assign in_ready = !hazard && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready && !flush;

   // The scoreboard is read from its registered state, so a LateALU
   // completion only unblocks a waiting reader on the following cycle.
   regread_scoreboard #(
      .NREG (NREG)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .set_en   (accept && long_op),
      .set_idx  (rd_index),
      .clr_en   (latealu_done),
      .clr_idx  (latealu_rd),
      .rd_idx_a (rs_index),
      .rd_idx_b (rt_index),
      .rd_idx_c (rd_index),
      .busy_a   (sb_busy_a),
      .busy_b   (sb_busy_b),
      .busy_c   (sb_busy_rd)
   );

   always_comb begin
      out_valid_d   = out_valid_q;
      rs_value_d    = rs_value_q;
      rt_value_d    = rt_value_q;
      out_rd_d      = out_rd_q;
      out_long_op_d = out_long_op_q;
      stall_d       = stall_q;

      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d   = 1'b1;
         rs_value_d    = op_a;
         rt_value_d    = op_b;
         out_rd_d      = rd_index;
         out_long_op_d = long_op;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      if (in_valid && hazard && !flush && (stall_q != '1)) begin
         stall_d = stall_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q   <= 1'b0;
         rs_value_q    <= '0;
         rt_value_q    <= '0;
         out_rd_q      <= '0;
         out_long_op_q <= 1'b0;
         stall_q       <= '0;
      end else begin
         out_valid_q   <= out_valid_d;
         rs_value_q    <= rs_value_d;
         rt_value_q    <= rt_value_d;
         out_rd_q      <= out_rd_d;
         out_long_op_q <= out_long_op_d;
         stall_q       <= stall_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign rs_value     = rs_value_q;
   assign rt_value     = rt_value_q;
   assign out_rd       = out_rd_q;
   assign out_long_op  = out_long_op_q;
   assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_regread.sv
// Directed bench for pipeline_regread: hand-computed expectations, with the
// EX/MEM bypass cases split on REGREAD_BYPASS_EN.
module tb_pipeline_regread;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  rs_index, rt_index, rd_index;
   logic        rs_used, rt_used, long_op;
   logic [4:0]  rindex_a, rindex_b;
   logic [31:0] rout_a, rout_b;
   logic        ex_valid, ex_is_load;
   logic [4:0]  ex_rd;
   logic [31:0] ex_value;
   logic        mem_valid;
   logic [4:0]  mem_rd;
   logic [31:0] mem_value;
   logic        we;
   logic [4:0]  windex;
   logic [31:0] win;
   logic        latealu_done;
   logic [4:0]  latealu_rd;
   logic        out_valid, out_ready;
   logic [31:0] rs_value, rt_value;
   logic [4:0]  out_rd;
   logic        out_long_op;
   logic [31:0] stall_cycles;

   logic [31:0] regs [32];
   int n_checks = 0;
   int n_errors = 0;
   int exp_stall = 0;

   assign rout_a = regs[rindex_a];
   assign rout_b = regs[rindex_b];

   pipeline_regread #(
      .NREG    (32),
      .DATA_W  (32),
      .STALL_W (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .rs_index     (rs_index),
      .rt_index     (rt_index),
      .rs_used      (rs_used),
      .rt_used      (rt_used),
      .rd_index     (rd_index),
      .long_op      (long_op),
      .rindex_a     (rindex_a),
      .rindex_b     (rindex_b),
      .rout_a       (rout_a),
      .rout_b       (rout_b),
      .ex_valid     (ex_valid),
      .ex_rd        (ex_rd),
      .ex_is_load   (ex_is_load),
      .ex_value     (ex_value),
      .mem_valid    (mem_valid),
      .mem_rd       (mem_rd),
      .mem_value    (mem_value),
      .we           (we),
      .windex       (windex),
      .win          (win),
      .latealu_done (latealu_done),
      .latealu_rd   (latealu_rd),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .rs_value     (rs_value),
      .rt_value     (rt_value),
      .out_rd       (out_rd),
      .out_long_op  (out_long_op),
      .stall_cycles (stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush = 0; in_valid = 0; rs_index = 0; rt_index = 0; rs_used = 0; rt_used = 0;
      rd_index = 0; long_op = 0; ex_valid = 0; ex_rd = 0; ex_is_load = 0; ex_value = 0;
      mem_valid = 0; mem_rd = 0; mem_value = 0; we = 0; windex = 0; win = 0;
      latealu_done = 0; latealu_rd = 0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + i;
      regs[0] = 32'h0;
      regs[3] = 32'd5;
      regs[8] = 32'd80;
      idle();
      out_ready = 1;
      rst = 1;
      step();
      step();
      check("rst_out_valid", out_valid, 0);
      check("rst_rs_value", rs_value, 0);
      check("rst_rt_value", rt_value, 0);
      check("rst_out_rd", out_rd, 0);
      check("rst_out_long_op", out_long_op, 0);
      check("rst_stall", stall_cycles, 0);
      rst = 0;
      #1;
      check("idle_in_ready", in_ready, 1);

      // plain regfile read, latency 1
      in_valid = 1; rs_index = 3; rs_used = 1; rd_index = 10;
      #1 check("rf_in_ready", in_ready, 1);
      step();
      check("rf_out_valid", out_valid, 1);
      check("rf_rs_value", rs_value, 5);
      check("rf_out_rd", out_rd, 10);
      idle();
      step();
      check("bubble_out_valid", out_valid, 0);

      // WB bypass on rs, regfile on rt
      in_valid = 1; rs_index = 5; rs_used = 1; rt_index = 6; rt_used = 1;
      we = 1; windex = 5; win = 32'h55;
      step();
      check("wb_rs_value", rs_value, 32'h55);
      check("wb_rt_value", rt_value, 32'h1006);
      idle();

      // EX bypass / EX no-bypass hazard
      ex_valid = 1; ex_rd = 4; ex_value = 9;
      in_valid = 1; rs_index = 4; rs_used = 1;
`ifdef REGREAD_BYPASS_EN
      #1 check("ex_in_ready", in_ready, 1);
      step();
      check("ex_rs_value", rs_value, 9);
`else
      #1 check("ex_in_ready", in_ready, 0);
      step();
      exp_stall++;
      check("ex_stall", stall_cycles, exp_stall);
      check("ex_out_valid", out_valid, 0);
`endif
      idle();
      step();

      // load-use on rt, then value from MEM (or WB without bypass)
      ex_valid = 1; ex_is_load = 1; ex_rd = 7; ex_value = 32'hDEAD;
      in_valid = 1; rt_index = 7; rt_used = 1; rd_index = 12;
      #1 check("lu_in_ready", in_ready, 0);
      step();
      exp_stall++;
      check("lu_stall", stall_cycles, exp_stall);
      ex_valid = 0; ex_is_load = 0;
      mem_valid = 1; mem_rd = 7; mem_value = 32'h77;
`ifdef REGREAD_BYPASS_EN
      #1 check("lu_mem_in_ready", in_ready, 1);
      step();
`else
      #1 check("lu_mem_in_ready", in_ready, 0);
      step();
      exp_stall++;
      check("lu_mem_stall", stall_cycles, exp_stall);
      mem_valid = 0; we = 1; windex = 7; win = 32'h77;
      #1 check("lu_wb_in_ready", in_ready, 1);
      step();
`endif
      check("lu_out_valid", out_valid, 1);
      check("lu_rt_value", rt_value, 32'h77);
      idle();
      step();

      // LateALU producer of r8, dependent read waits for completion + 1
      in_valid = 1; long_op = 1; rd_index = 8;
      #1 check("long_in_ready", in_ready, 1);
      step();
      check("long_out_long_op", out_long_op, 1);
      check("long_out_rd", out_rd, 8);
      idle();
      in_valid = 1; rs_index = 8; rs_used = 1; rd_index = 11;
      #1 check("sb_in_ready0", in_ready, 0);
      step();
      exp_stall++;
      step();
      exp_stall++;
      latealu_done = 1; latealu_rd = 8;
      #1 check("sb_done_same_cycle", in_ready, 0);
      step();
      exp_stall++;
      latealu_done = 0;
      #1 check("sb_released", in_ready, 1);
      check("sb_stall", stall_cycles, exp_stall);
      step();
      check("sb_out_valid", out_valid, 1);
      check("sb_rs_value", rs_value, 80);
      check("sb_out_rd", out_rd, 11);
      idle();
      step();

      // index 0 reads zero, long_op to r0 sets nothing
      ex_valid = 1; ex_rd = 0; ex_value = 32'hFFFF;
      in_valid = 1; rs_index = 0; rs_used = 1; long_op = 1; rd_index = 0;
      #1 check("r0_in_ready", in_ready, 1);
      step();
      check("r0_rs_value", rs_value, 0);
      check("r0_out_long_op", out_long_op, 1);
      #1 check("r0_no_waw", in_ready, 1);
      step();
      idle();
      step();

      // backpressure, WAW, then flush clears scoreboard and output
      in_valid = 1; long_op = 1; rd_index = 8;
      step();
      check("fl_out_valid", out_valid, 1);
      idle();
      out_ready = 0;
      in_valid = 1; rs_index = 2; rs_used = 1;
      #1 check("bp_in_ready", in_ready, 0);
      step();
      check("bp_out_valid", out_valid, 1);
      check("bp_out_rd", out_rd, 8);
      check("bp_no_stall", stall_cycles, exp_stall);
      rs_used = 0; long_op = 1; rd_index = 8;
      #1 check("waw_in_ready", in_ready, 0);
      step();
      exp_stall++;
      check("waw_stall", stall_cycles, exp_stall);
      long_op = 0; rs_index = 8; rs_used = 1; rd_index = 13; flush = 1;
      step();
      check("flush_out_valid", out_valid, 0);
      check("flush_stall", stall_cycles, exp_stall);
      flush = 0; out_ready = 1;
      #1 check("post_flush_in_ready", in_ready, 1);
      step();
      check("post_flush_out_valid", out_valid, 1);
      check("post_flush_rs_value", rs_value, 80);
      idle();
      step();

      // reset in the middle of a stall
      ex_valid = 1; ex_is_load = 1; ex_rd = 9;
      in_valid = 1; rs_index = 9; rs_used = 1;
      step();
      exp_stall++;
      check("mid_stall", stall_cycles, exp_stall);
      rst = 1;
      step();
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_stall", stall_cycles, 0);
      rst = 0;
      idle();
      step();
      check("mid_rst_after", out_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
